ucore_sequencer: RTL and testbench
==================================

Name: ucore_sequencer

Overview:
Parametrised microcode sequencer, the successor to the generated fixed-state microcoder FSM cores. Program state is no longer hard-wired states. The block holds a program counter (PC) and steps through a microprogram held in an external asynchronous ROM. It supports conditional branches, wait-on-condition, and subroutine call/return through a hardware call stack. It sits between the microprogram ROM and the datapath, driving the datapath control word each cycle.

Parameters:
PC_W, 8, PC / ROM address width; PC wraps mod 2^PC_W.
CTRL_W, 16, width of the datapath control word.
COND_W, 8, number of condition inputs; must be a power of two and at least 2.
STACK_DEPTH, 4, call stack entries; must be at least 1.
RESET_PC, 0, PC entry point after reset and on start.

Ports:
clk  input  1  clock, rising-edge.
resetn  input  1  asynchronous active-low reset.
start  input  1  launches the program from RESET_PC when in IDLE, HALT or ERROR.
cond  input  COND_W  datapath condition flags.
pc  output  PC_W  ROM address.
i_op  input  3  opcode of the instruction at pc.
i_cond_sel  input  $clog2(COND_W)  index of the condition bit to test.
i_cond_inv  input  1  inverts the selected condition.
i_target  input  PC_W  jump / branch / call target.
i_ctrl  input  CTRL_W  control word of the instruction at pc.
ctrl_out  output  CTRL_W  control word to the datapath.
busy  output  1  high while in RUN.
halted  output  1  high while in HALT.
stack_err  output  1  high while in ERROR.

Behaviour:
- Reset, clk and resetn (already decided): reset resetn, asynchronous, active-low; clock clk.
- Values during reset:
  - state=IDLE, pc=RESET_PC, stack pointer sp=0.
  - ctrl_out=0, busy=0, halted=0, stack_err=0.
- States: IDLE, RUN, HALT, ERROR.
  - IDLE, HALT, ERROR + start=1 -> RUN; pc<=RESET_PC; sp<=0.
  - Otherwise these states hold, and pc holds.
- RUN: one instruction executes per cycle.
  - ctrl_out = i_ctrl (combinational from ROM) only in RUN; 0 in every other state.
  - c = cond[i_cond_sel] ^ i_cond_inv.
- Opcodes, all applied at the next clock edge:
  - 0 NEXT: pc<=pc+1.
  - 1 JUMP: pc<=i_target.
  - 2 BRANCH: pc <= c ? i_target : pc+1.
  - 3 WAIT: pc <= c ? pc+1 : pc. ctrl_out stays asserted for every stall cycle.
  - 4 CALL: push pc+1; pc<=i_target.
  - 5 RET: pop; pc<=popped value.
  - 6 HALT: state<=HALT; pc holds. ctrl_out is asserted for this final cycle.
  - 7 reserved: executes as NEXT.
- Latency: start sampled at edge N. The first instruction is presented and executed during cycle N+1.
- Arithmetic: pc+1 is PC_W-bit modulo; 2^PC_W-1 wraps to 0. The pushed return address wraps the same way.
- Stack boundary conditions:
  - CALL with sp==STACK_DEPTH (full): no push, pc holds, state<=ERROR.
  - RET with sp==0 (empty): no pop, pc holds, state<=ERROR.
  - CALL exactly filling the stack (sp STACK_DEPTH-1 -> STACK_DEPTH) is legal.
  - ctrl_out is still asserted for the faulting cycle.
- start while in RUN is ignored.
- An asynchronous reset mid-program returns to IDLE immediately and discards stack contents.
- Only the block's internal registers are sampled. The i_* fields are treated as a pure function of pc.

Decomposition:
- Shared package ucore_pkg holds:
  - opcode localparams (UC_NEXT..UC_RSVD, 3-bit);
  - state encoding localparams (2-bit);
  - the field-width helper for cond_sel.
- One sub-module: ucore_call_stack.
  - Parameters: PC_W, STACK_DEPTH.
  - Ports: push, pop, clear, wdata, rdata, full, empty.
  - LIFO register array with a pointer; async reset clears only the pointer.
  - push and pop are never asserted together.
- The top level holds the FSM, PC register, condition mux and next-PC mux.

Test Plan:
- Linear program: ROM 0..3 = NEXT,NEXT,NEXT,HALT; i_ctrl=addr+0x10; pulse start.
  -> ctrl_out = 0x10,0x11,0x12,0x13 on consecutive cycles, then halted=1, pc=3, ctrl_out=0.
- Branch and wait: addr0 = BRANCH sel=2 inv=0 tgt=5; addr5 = WAIT sel=1; addr6 = HALT.
  - cond=0x04 -> pc goes 0 -> 5.
  - Hold cond[1]=0 for 3 cycles -> pc stays at 5 for 3 cycles.
  - Raise cond[1] -> pc=6, then HALT.
  - Repeat with inv=1 -> pc goes 0 -> 1.
- Call/return with STACK_DEPTH=4: 4 nested CALLs then 4 RETs.
  -> Return addresses are restored in LIFO order; stack_err stays 0.
  -> A 5th nested CALL -> stack_err=1, pc holds at the CALL address.
- Underflow: RET at addr0 with an empty stack.
  -> stack_err=1 the next cycle, pc=0.
  -> start -> RUN, pc=RESET_PC, sp=0.
- Wrap: PC_W=4, JUMP to 15 where ROM holds NEXT.
  -> pc goes 15 -> 0.
  -> CALL at 15 pushes 0; the subsequent RET returns to 0.
- Reset mid-operation: assert resetn=0 asynchronously during a WAIT stall with sp=2.
  -> Immediately pc=RESET_PC, ctrl_out=0, busy=0.
  -> After restart, RET at entry -> stack_err (stack was cleared).

Source files
------------

// File: rtl/ucore_pkg.sv
// ucore_pkg: shared definitions for the microcode sequencer slice.
//   - UC_* opcode encodings (3-bit) decoded by the sequencer.
//   - Sequencer state encoding (2-bit) and the matching enum type.
//   - cond_sel_w(): width of the condition-select field for a given COND_W.
package ucore_pkg;

    localparam logic [2:0] UC_NEXT   = 3'd0;
    localparam logic [2:0] UC_JUMP   = 3'd1;
    localparam logic [2:0] UC_BRANCH = 3'd2;
    localparam logic [2:0] UC_WAIT   = 3'd3;
    localparam logic [2:0] UC_CALL   = 3'd4;
    localparam logic [2:0] UC_RET    = 3'd5;
    localparam logic [2:0] UC_HALT   = 3'd6;
    localparam logic [2:0] UC_RSVD   = 3'd7;

    localparam logic [1:0] UC_ST_IDLE  = 2'd0;
    localparam logic [1:0] UC_ST_RUN   = 2'd1;
    localparam logic [1:0] UC_ST_HALT  = 2'd2;
    localparam logic [1:0] UC_ST_ERROR = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = UC_ST_IDLE,
        ST_RUN   = UC_ST_RUN,
        ST_HALT  = UC_ST_HALT,
        ST_ERROR = UC_ST_ERROR
    } uc_state_t;

    // Bits needed to index one of cond_w condition flags (cond_w is a power of two).
    function automatic int cond_sel_w(input int cond_w);
        return $clog2(cond_w);
    endfunction

endpackage

// File: rtl/ucore_call_stack.sv
// ucore_call_stack: LIFO of return addresses for CALL/RET.
//   clk, resetn      : clock, asynchronous active-low reset (clears pointer only)
//   push / pop       : push wdata / discard top entry (never both at once)
//   clear            : synchronous pointer clear, wins over push/pop
//   wdata / rdata    : address to push / current top-of-stack
//   full / empty     : pointer at STACK_DEPTH / at zero
module ucore_call_stack #(
    parameter int PC_W        = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            push,
    input  logic            pop,
    input  logic            clear,
    input  logic [PC_W-1:0] wdata,
    output logic [PC_W-1:0] rdata,
    output logic            full,
    output logic            empty
);

    localparam int SP_W = $clog2(STACK_DEPTH + 1);
    // Entry index width; kept at least 1 so a single-entry stack still has an index.
    localparam int AW   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [SP_W-1:0] sp_q;
    logic [SP_W-1:0] sp_d;
    logic [PC_W-1:0] mem_q [0:(1 << AW) - 1];
    logic [AW-1:0]   wr_idx_s;
    logic [AW-1:0]   rd_idx_s;

    assign full     = (sp_q == SP_W'(STACK_DEPTH));
    assign empty    = (sp_q == {SP_W{1'b0}});
    assign wr_idx_s = AW'(sp_q);
    assign rd_idx_s = AW'(sp_q - SP_W'(1));
    assign rdata    = mem_q[rd_idx_s];

    // Next stack pointer: clear has priority, push/pop guarded against full/empty.
    always_comb begin
        sp_d = sp_q;
        if (clear) begin
            sp_d = {SP_W{1'b0}};
        end else if (push && !full) begin
            sp_d = sp_q + SP_W'(1);
        end else if (pop && !empty) begin
            sp_d = sp_q - SP_W'(1);
        end else begin
            sp_d = sp_q;
        end
    end

    // Stack pointer register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sp_q <= {SP_W{1'b0}};
        end else begin
            sp_q <= sp_d;
        end
    end

    // Entry storage; contents are don't-care until pushed, so no reset.
    always_ff @(posedge clk) begin
        if (push && !full && !clear) begin
            mem_q[wr_idx_s] <= wdata;
        end
    end

endmodule

// File: rtl/ucore_sequencer.sv
// ucore_sequencer: microcode sequencer stepping a PC through an external async ROM.
//   clk, resetn           : clock, asynchronous active-low reset
//   start                 : launch from RESET_PC when IDLE/HALT/ERROR (ignored in RUN)
//   cond                  : datapath condition flags
//   pc                    : ROM address
//   i_op .. i_ctrl        : fields of the instruction currently at pc
//   ctrl_out              : i_ctrl while in RUN, zero otherwise
//   busy/halted/stack_err : state is RUN / HALT / ERROR
module ucore_sequencer
    import ucore_pkg::*;
#(
    parameter int PC_W        = 8,
    parameter int CTRL_W      = 16,
    parameter int COND_W      = 8,
    parameter int STACK_DEPTH = 4,
    parameter int RESET_PC    = 0
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          start,
    input  logic [COND_W-1:0]             cond,
    output logic [PC_W-1:0]               pc,
    input  logic [2:0]                    i_op,
    input  logic [cond_sel_w(COND_W)-1:0] i_cond_sel,
    input  logic                          i_cond_inv,
    input  logic [PC_W-1:0]               i_target,
    input  logic [CTRL_W-1:0]             i_ctrl,
    output logic [CTRL_W-1:0]             ctrl_out,
    output logic                          busy,
    output logic                          halted,
    output logic                          stack_err
);

    localparam logic [PC_W-1:0] ENTRY_PC = PC_W'(RESET_PC);

    uc_state_t         state_q;
    uc_state_t         state_d;
    logic [PC_W-1:0]   pc_q;
    logic [PC_W-1:0]   pc_d;
    logic [PC_W-1:0]   pc_inc_s;
    logic [PC_W-1:0]   stk_rdata_s;
    logic [CTRL_W-1:0] ctrl_s;
    logic              cond_s;
    logic              push_s;
    logic              pop_s;
    logic              clear_s;
    logic              full_s;
    logic              empty_s;

    // Wraps modulo 2^PC_W; also used as the pushed return address.
    assign pc_inc_s = pc_q + PC_W'(1);
    assign cond_s   = cond[i_cond_sel] ^ i_cond_inv;

    ucore_call_stack #(
        .PC_W        (PC_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_call_stack (
        .clk    (clk),
        .resetn (resetn),
        .push   (push_s),
        .pop    (pop_s),
        .clear  (clear_s),
        .wdata  (pc_inc_s),
        .rdata  (stk_rdata_s),
        .full   (full_s),
        .empty  (empty_s)
    );

    // Next state, next PC, stack controls and control word.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        push_s  = 1'b0;
        pop_s   = 1'b0;
        clear_s = 1'b0;
        ctrl_s  = {CTRL_W{1'b0}};
        case (state_q)
            ST_RUN: begin
                // The executing instruction's control word is driven even on
                // stall, halt and stack-fault cycles.
                ctrl_s = i_ctrl;
                case (i_op)
                    UC_JUMP:   pc_d = i_target;
                    UC_BRANCH: pc_d = cond_s ? i_target : pc_inc_s;
                    UC_WAIT:   pc_d = cond_s ? pc_inc_s : pc_q;
                    UC_CALL: begin
                        if (full_s) begin
                            state_d = ST_ERROR;
                        end else begin
                            push_s = 1'b1;
                            pc_d   = i_target;
                        end
                    end
                    UC_RET: begin
                        if (empty_s) begin
                            state_d = ST_ERROR;
                        end else begin
                            pop_s = 1'b1;
                            pc_d  = stk_rdata_s;
                        end
                    end
                    UC_HALT:   state_d = ST_HALT;
                    // UC_NEXT and the reserved opcode both step to pc+1.
                    default:   pc_d = pc_inc_s;
                endcase
            end
            default: begin
                if (start) begin
                    state_d = ST_RUN;
                    pc_d    = ENTRY_PC;
                    clear_s = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
        endcase
    end

    // State and PC registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            pc_q    <= ENTRY_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    assign pc        = pc_q;
    assign ctrl_out  = ctrl_s;
    assign busy      = (state_q == ST_RUN);
    assign halted    = (state_q == ST_HALT);
    assign stack_err = (state_q == ST_ERROR);

endmodule

// File: tb/tb_ucore_sequencer.sv
module tb_ucore_sequencer;

    typedef struct packed {
        logic [7:0]  pc;
        logic [15:0] ctrl;
        logic        busy;
        logic        halted;
        logic        err;
    } obs_t;

    localparam logic [1:0] S_I = 2'd0;
    localparam logic [1:0] S_R = 2'd1;
    localparam logic [1:0] S_H = 2'd2;
    localparam logic [1:0] S_E = 2'd3;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    logic start  = 1'b0;
    logic start4 = 1'b0;
    logic [7:0] cond = 8'h00;

    // 8-bit PC instance
    logic [7:0]  pc;
    logic [2:0]  i_op;
    logic [2:0]  i_cond_sel;
    logic        i_cond_inv;
    logic [7:0]  i_target;
    logic [15:0] i_ctrl;
    logic [15:0] ctrl_out;
    logic        busy, halted, stack_err;
    logic [2:0]  rom_op  [0:255];
    logic [2:0]  rom_sel [0:255];
    logic        rom_inv [0:255];
    logic [7:0]  rom_tgt [0:255];

    assign i_op       = rom_op[pc];
    assign i_cond_sel = rom_sel[pc];
    assign i_cond_inv = rom_inv[pc];
    assign i_target   = rom_tgt[pc];
    assign i_ctrl     = {8'h00, pc} + 16'h0010;

    // 4-bit PC instance (entry point 2)
    logic [3:0]  pc4;
    logic [2:0]  i_op4;
    logic [2:0]  i_cond_sel4;
    logic        i_cond_inv4;
    logic [3:0]  i_target4;
    logic [15:0] i_ctrl4;
    logic [15:0] ctrl_out4;
    logic        busy4, halted4, err4;
    logic [2:0]  rom4_op  [0:15];
    logic [3:0]  rom4_tgt [0:15];

    assign i_op4       = rom4_op[pc4];
    assign i_cond_sel4 = 3'd0;
    assign i_cond_inv4 = 1'b0;
    assign i_target4   = rom4_tgt[pc4];
    assign i_ctrl4     = {12'h000, pc4} + 16'h0010;

    ucore_sequencer #(.PC_W(8), .CTRL_W(16), .COND_W(8), .STACK_DEPTH(4), .RESET_PC(0)) u_dut (
        .clk(clk), .resetn(resetn), .start(start), .cond(cond), .pc(pc),
        .i_op(i_op), .i_cond_sel(i_cond_sel), .i_cond_inv(i_cond_inv),
        .i_target(i_target), .i_ctrl(i_ctrl), .ctrl_out(ctrl_out),
        .busy(busy), .halted(halted), .stack_err(stack_err)
    );

    ucore_sequencer #(.PC_W(4), .CTRL_W(16), .COND_W(8), .STACK_DEPTH(4), .RESET_PC(2)) u_dut4 (
        .clk(clk), .resetn(resetn), .start(start4), .cond(cond), .pc(pc4),
        .i_op(i_op4), .i_cond_sel(i_cond_sel4), .i_cond_inv(i_cond_inv4),
        .i_target(i_target4), .i_ctrl(i_ctrl4), .ctrl_out(ctrl_out4),
        .busy(busy4), .halted(halted4), .stack_err(err4)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    obs_t sb[$];
    obs_t exp_v;
    obs_t obs_v;

    // Expected observation: control word is addr+0x10 only while running.
    function automatic obs_t mk(input logic [7:0] p, input logic [1:0] st);
        obs_t o;
        o.pc     = p;
        o.ctrl   = (st == S_R) ? ({8'h00, p} + 16'h0010) : 16'h0000;
        o.busy   = (st == S_R);
        o.halted = (st == S_H);
        o.err    = (st == S_E);
        return o;
    endfunction

    task automatic rom_clear();
        for (int i = 0; i < 256; i++) begin
            rom_op[i] = 3'd0; rom_sel[i] = 3'd0; rom_inv[i] = 1'b0; rom_tgt[i] = 8'd0;
        end
        for (int i = 0; i < 16; i++) begin
            rom4_op[i] = 3'd0; rom4_tgt[i] = 4'd0;
        end
    endtask

    task automatic test_reset();
        sb.push_back(mk(8'd0, S_I));
        #12;
        exp_v = sb.pop_front();
        obs_v = {pc, ctrl_out, busy, halted, stack_err};
        checks++;
        if (obs_v !== exp_v) begin
            errors++;
            $display("FAIL reset got pc=%h ctrl=%h bhe=%b exp pc=%h ctrl=%h bhe=%b",
                     obs_v.pc, obs_v.ctrl, {obs_v.busy, obs_v.halted, obs_v.err},
                     exp_v.pc, exp_v.ctrl, {exp_v.busy, exp_v.halted, exp_v.err});
        end
        @(negedge clk); resetn = 1'b1;
    endtask

    task automatic test_linear();
        rom_clear();
        rom_op[3] = 3'd6;
        cond = 8'h00;
        sb.push_back(mk(8'd0, S_R)); sb.push_back(mk(8'd1, S_R));
        sb.push_back(mk(8'd2, S_R)); sb.push_back(mk(8'd3, S_R));
        sb.push_back(mk(8'd3, S_H)); sb.push_back(mk(8'd3, S_H));
        @(negedge clk); start = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            // start held for one extra RUN cycle must be ignored
            if (k == 1) start = 1'b0;
            exp_v = sb.pop_front();
            obs_v = {pc, ctrl_out, busy, halted, stack_err};
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL linear[%0d] got pc=%h ctrl=%h bhe=%b exp pc=%h ctrl=%h bhe=%b", k,
                         obs_v.pc, obs_v.ctrl, {obs_v.busy, obs_v.halted, obs_v.err},
                         exp_v.pc, exp_v.ctrl, {exp_v.busy, exp_v.halted, exp_v.err});
            end
        end
    endtask

    task automatic test_branch_wait();
        rom_clear();
        rom_op[0] = 3'd2; rom_sel[0] = 3'd2; rom_inv[0] = 1'b0; rom_tgt[0] = 8'd5;
        rom_op[5] = 3'd3; rom_sel[5] = 3'd1;
        rom_op[6] = 3'd6;
        cond = 8'h04;
        sb.push_back(mk(8'd0, S_R));
        sb.push_back(mk(8'd5, S_R)); sb.push_back(mk(8'd5, S_R)); sb.push_back(mk(8'd5, S_R));
        sb.push_back(mk(8'd6, S_R)); sb.push_back(mk(8'd6, S_H));
        @(negedge clk); start = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk); start = 1'b0;
            exp_v = sb.pop_front();
            obs_v = {pc, ctrl_out, busy, halted, stack_err};
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL branch_wait[%0d] got pc=%h ctrl=%h bhe=%b exp pc=%h ctrl=%h bhe=%b", k,
                         obs_v.pc, obs_v.ctrl, {obs_v.busy, obs_v.halted, obs_v.err},
                         exp_v.pc, exp_v.ctrl, {exp_v.busy, exp_v.halted, exp_v.err});
            end
            if (k == 3) cond = 8'h06;
        end
    endtask

    task automatic test_branch_inv();
        rom_clear();
        rom_op[0] = 3'd2; rom_sel[0] = 3'd2; rom_inv[0] = 1'b1; rom_tgt[0] = 8'd5;
        rom_op[1] = 3'd6;
        rom_op[5] = 3'd6;
        cond = 8'h04;
        sb.push_back(mk(8'd0, S_R)); sb.push_back(mk(8'd1, S_R)); sb.push_back(mk(8'd1, S_H));
        @(negedge clk); start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); start = 1'b0;
            exp_v = sb.pop_front();
            obs_v = {pc, ctrl_out, busy, halted, stack_err};
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL branch_inv[%0d] got pc=%h ctrl=%h bhe=%b exp pc=%h ctrl=%h bhe=%b", k,
                         obs_v.pc, obs_v.ctrl, {obs_v.busy, obs_v.halted, obs_v.err},
                         exp_v.pc, exp_v.ctrl, {exp_v.busy, exp_v.halted, exp_v.err});
            end
        end
    endtask

    // Four nested calls (fills the stack exactly), then unwind.
    task automatic test_call_ret();
        rom_clear();
        rom_op[0]  = 3'd4; rom_tgt[0]  = 8'd10;
        rom_op[10] = 3'd4; rom_tgt[10] = 8'd20;
        rom_op[20] = 3'd4; rom_tgt[20] = 8'd30;
        rom_op[30] = 3'd4; rom_tgt[30] = 8'd40;
        rom_op[40] = 3'd5; rom_op[31] = 3'd5; rom_op[21] = 3'd5; rom_op[11] = 3'd5;
        rom_op[1]  = 3'd6;
        sb.push_back(mk(8'd0, S_R));  sb.push_back(mk(8'd10, S_R)); sb.push_back(mk(8'd20, S_R));
        sb.push_back(mk(8'd30, S_R)); sb.push_back(mk(8'd40, S_R)); sb.push_back(mk(8'd31, S_R));
        sb.push_back(mk(8'd21, S_R)); sb.push_back(mk(8'd11, S_R)); sb.push_back(mk(8'd1, S_R));
        sb.push_back(mk(8'd1, S_H));
        @(negedge clk); start = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk); start = 1'b0;
            exp_v = sb.pop_front();
            obs_v = {pc, ctrl_out, busy, halted, stack_err};
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL call_ret[%0d] got pc=%h ctrl=%h bhe=%b exp pc=%h ctrl=%h bhe=%b", k,
                         obs_v.pc, obs_v.ctrl, {obs_v.busy, obs_v.halted, obs_v.err},
                         exp_v.pc, exp_v.ctrl, {exp_v.busy, exp_v.halted, exp_v.err});
            end
        end
    endtask

    task automatic test_overflow();
        rom_clear();
        rom_op[0]  = 3'd4; rom_tgt[0]  = 8'd10;
        rom_op[10] = 3'd4; rom_tgt[10] = 8'd20;
        rom_op[20] = 3'd4; rom_tgt[20] = 8'd30;
        rom_op[30] = 3'd4; rom_tgt[30] = 8'd40;
        rom_op[40] = 3'd4; rom_tgt[40] = 8'd50;
        sb.push_back(mk(8'd0, S_R));  sb.push_back(mk(8'd10, S_R)); sb.push_back(mk(8'd20, S_R));
        sb.push_back(mk(8'd30, S_R)); sb.push_back(mk(8'd40, S_R));
        sb.push_back(mk(8'd40, S_E)); sb.push_back(mk(8'd40, S_E));
        @(negedge clk); start = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk); start = 1'b0;
            exp_v = sb.pop_front();
            obs_v = {pc, ctrl_out, busy, halted, stack_err};
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL overflow[%0d] got pc=%h ctrl=%h bhe=%b exp pc=%h ctrl=%h bhe=%b", k,
                         obs_v.pc, obs_v.ctrl, {obs_v.busy, obs_v.halted, obs_v.err},
                         exp_v.pc, exp_v.ctrl, {exp_v.busy, exp_v.halted, exp_v.err});
            end
        end
    endtask

    // RET on an empty stack, then restart out of ERROR.
    task automatic test_underflow();
        rom_clear();
        rom_op[0] = 3'd5;
        sb.push_back(mk(8'd0, S_R)); sb.push_back(mk(8'd0, S_E)); sb.push_back(mk(8'd0, S_E));
        sb.push_back(mk(8'd0, S_R)); sb.push_back(mk(8'd0, S_E));
        @(negedge clk); start = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); start = 1'b0;
            exp_v = sb.pop_front();
            obs_v = {pc, ctrl_out, busy, halted, stack_err};
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL underflow[%0d] got pc=%h ctrl=%h bhe=%b exp pc=%h ctrl=%h bhe=%b", k,
                         obs_v.pc, obs_v.ctrl, {obs_v.busy, obs_v.halted, obs_v.err},
                         exp_v.pc, exp_v.ctrl, {exp_v.busy, exp_v.halted, exp_v.err});
            end
            if (k == 2) start = 1'b1;
        end
    endtask

    // 4-bit PC: NEXT at 15 wraps to 0; CALL at 15 pushes 0.
    task automatic test_wrap();
        rom_clear();
        rom4_op[2]  = 3'd1; rom4_tgt[2] = 4'd15;
        rom4_op[0]  = 3'd6;
        sb.push_back(mk(8'd2, S_R)); sb.push_back(mk(8'd15, S_R));
        sb.push_back(mk(8'd0, S_R)); sb.push_back(mk(8'd0, S_H));
        @(negedge clk); start4 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); start4 = 1'b0;
            exp_v = sb.pop_front();
            obs_v = {4'h0, pc4, ctrl_out4, busy4, halted4, err4};
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL wrap_next[%0d] got pc=%h ctrl=%h bhe=%b exp pc=%h ctrl=%h bhe=%b", k,
                         obs_v.pc, obs_v.ctrl, {obs_v.busy, obs_v.halted, obs_v.err},
                         exp_v.pc, exp_v.ctrl, {exp_v.busy, exp_v.halted, exp_v.err});
            end
        end
        rom4_op[15] = 3'd4; rom4_tgt[15] = 4'd5;
        rom4_op[5]  = 3'd5;
        sb.push_back(mk(8'd2, S_R)); sb.push_back(mk(8'd15, S_R)); sb.push_back(mk(8'd5, S_R));
        sb.push_back(mk(8'd0, S_R)); sb.push_back(mk(8'd0, S_H));
        @(negedge clk); start4 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); start4 = 1'b0;
            exp_v = sb.pop_front();
            obs_v = {4'h0, pc4, ctrl_out4, busy4, halted4, err4};
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL wrap_call[%0d] got pc=%h ctrl=%h bhe=%b exp pc=%h ctrl=%h bhe=%b", k,
                         obs_v.pc, obs_v.ctrl, {obs_v.busy, obs_v.halted, obs_v.err},
                         exp_v.pc, exp_v.ctrl, {exp_v.busy, exp_v.halted, exp_v.err});
            end
        end
    endtask

    // Async reset while stalled on WAIT with two frames on the stack.
    task automatic test_reset_mid();
        rom_clear();
        rom_op[0]  = 3'd4; rom_tgt[0]  = 8'd10;
        rom_op[10] = 3'd4; rom_tgt[10] = 8'd20;
        rom_op[20] = 3'd3; rom_sel[20] = 3'd1;
        cond = 8'h00;
        sb.push_back(mk(8'd0, S_R));  sb.push_back(mk(8'd10, S_R));
        sb.push_back(mk(8'd20, S_R)); sb.push_back(mk(8'd20, S_R));
        sb.push_back(mk(8'd0, S_I));
        @(negedge clk); start = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k < 4) begin
                @(negedge clk); start = 1'b0;
            end else begin
                #2 resetn = 1'b0;
                #1;
            end
            exp_v = sb.pop_front();
            obs_v = {pc, ctrl_out, busy, halted, stack_err};
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL reset_mid[%0d] got pc=%h ctrl=%h bhe=%b exp pc=%h ctrl=%h bhe=%b", k,
                         obs_v.pc, obs_v.ctrl, {obs_v.busy, obs_v.halted, obs_v.err},
                         exp_v.pc, exp_v.ctrl, {exp_v.busy, exp_v.halted, exp_v.err});
            end
        end
        @(negedge clk); resetn = 1'b1;
        rom_op[0] = 3'd5;
        sb.push_back(mk(8'd0, S_R)); sb.push_back(mk(8'd0, S_E));
        @(negedge clk); start = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); start = 1'b0;
            exp_v = sb.pop_front();
            obs_v = {pc, ctrl_out, busy, halted, stack_err};
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL reset_restart[%0d] got pc=%h ctrl=%h bhe=%b exp pc=%h ctrl=%h bhe=%b", k,
                         obs_v.pc, obs_v.ctrl, {obs_v.busy, obs_v.halted, obs_v.err},
                         exp_v.pc, exp_v.ctrl, {exp_v.busy, exp_v.halted, exp_v.err});
            end
        end
    endtask

    initial begin
        rom_clear();
        test_reset();
        test_linear();
        test_branch_wait();
        test_branch_inv();
        test_call_ret();
        test_overflow();
        test_underflow();
        test_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
